multicycle_controller: RTL and testbench

Main sequencing FSM for the multicycle RV32I core. It decodes the instruction-register fields and steps the shared datapath (PC, memory port, register file, ALU, immediate extension) through fetch, decode, execute, memory and writeback. It drives the immediate-extension select, ALU operand and operation selects, write enables and memory handshake, and counts retired instructions. It sits beside the datapath and is the only source of datapath control.

---
 rtl/multicycle_controller.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main sequencing FSM for the multicycle RV32I core. It decodes the IR fields
// and steps the shared datapath through fetch, decode, execute, memory and
// writeback. It also counts retired instructions.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous reset, active-low
//   op           instruction[6:0]
//   funct3       instruction[14:12]
//   funct7_5     instruction[30]
//   zero         ALU zero flag
//   mem_ready    memory has completed the current access
//   pc_write     PC load enable
//   adr_src      memory address select (0 = PC, 1 = ALUOut)
//   mem_write    memory write strobe
//   ir_write     IR / OldPC load enable
//   result_src   result mux select
//   alu_src_a    ALU A select
//   alu_src_b    ALU B select
//   alu_control  ALU operation
//   imm_src      immediate-extension select
//   reg_write    register-file write enable
//   trap         illegal instruction seen, sticky until reset
//   retired      count of completed instructions (wraps mod 2^32)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH     | read instruction at PC, PC <- PC+4 when memory is ready
// DECODE    | register read, branch target into ALUOut
// MEM_ADR   | effective address rs1 + imm for lw/sw
// MEM_READ  | load access, wait for mem_ready
// MEM_WB    | write loaded data to rd
// MEM_WRITE | store access, strobe held until mem_ready
// EXEC_R    | register-register ALU operation
// EXEC_I    | register-immediate ALU operation
// LUI       | 0 + upper immediate
// ALU_WB    | write ALUOut to rd
// BRANCH    | compare rs1/rs2, load PC from ALUOut if taken
// ILLEGAL   | unsupported instruction, absorbing until reset
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        adr_src,
  output logic        mem_write,
  output logic        ir_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_control,
  output logic [1:0]  imm_src,
  output logic        reg_write,
  output logic        trap,
  output logic [31:0] retired
);

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_EXEC_R, S_EXEC_I, S_LUI, S_ALU_WB, S_BRANCH, S_ILLEGAL
  } state_t;

  state_t      state_q, state_next;
  logic [31:0] retired_q;
  logic        alu_f3_ok;
  logic        legal;
  logic [2:0]  alu_fn;
  logic        retire;

  // funct3 values shared by the R and I ALU groups
  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                     (funct3 == 3'b110) || (funct3 == 3'b010);

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_LUI: legal = 1'b1;
      OP_R, OP_I:           legal = alu_f3_ok;
      OP_BRANCH:            legal = (funct3 == 3'b000) || (funct3 == 3'b001);
      default:              legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b111:  alu_fn = ALU_AND;
      3'b110:  alu_fn = ALU_OR;
      3'b010:  alu_fn = ALU_SLT;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next  = state_q;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 2'b00;
    reg_write   = 1'b0;
    trap        = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_SW:     imm_src = 2'b01;
          OP_BRANCH: imm_src = 2'b10;
          OP_LUI:    imm_src = 2'b11;
          default:   imm_src = 2'b00;
        endcase
        if (!legal) state_next = S_ILLEGAL;
        else begin
          case (op)
            OP_LW, OP_SW: state_next = S_MEM_ADR;
            OP_R:         state_next = S_EXEC_R;
            OP_I:         state_next = S_EXEC_I;
            OP_BRANCH:    state_next = S_BRANCH;
            OP_LUI:       state_next = S_LUI;
            default:      state_next = S_ILLEGAL;
          endcase
        end
      end
      S_MEM_ADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = (op == OP_SW) ? 2'b01 : 2'b00;
        state_next = (op == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = (funct3 == 3'b000 && funct7_5) ? ALU_SUB : alu_fn;
        state_next  = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_fn;
        state_next  = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a  = 2'b11;
        alu_src_b  = 2'b01;
        imm_src    = 2'b11;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        // funct3[0] distinguishes bne from beq
        pc_write    = funct3[0] ? ~zero : zero;
        state_next  = S_FETCH;
      end
      S_ILLEGAL: trap = 1'b1;
      default:   state_next = S_FETCH;
    endcase
  end

  assign retire = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
                  (state_q == S_BRANCH) ||
                  (state_q == S_MEM_WRITE && mem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_next;
      if (retire) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_LUI = 7'b0110111;

  logic clk = 1'b0, rst = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, adr_src, mem_write, ir_write, reg_write, trap;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [31:0] retired;

  typedef struct packed {
    logic pc_write, adr_src, mem_write, ir_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
    logic reg_write, trap;
    logic [31:0] retired;
  } outs_t;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .zero(zero), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .imm_src(imm_src), .reg_write(reg_write), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  outs_t act;
  assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                alu_src_b, alu_control, imm_src, reg_write, trap, retired};

  // per-cycle expectation from the model
  outs_t exp_o = '0;
  bit    exp_valid = 1'b0;
  string exp_name = "";
  // hand-computed literal expectations, masked to the fields they pin
  outs_t lit_exp = '0, lit_mask = '0;
  string lit_name = "";
  int    lit_seq = 0, lit_seen = 0;

  int n_checks = 0, n_errors = 0;
  int unsigned mdl_retired = 0;

  always @(negedge clk) begin
    int nc, ne;
    nc = 0; ne = 0;
    if (exp_valid) begin
      nc++;
      if (act !== exp_o) begin
        ne++;
        $display("FAIL %s: got %h expected %h (pc_write..retired packed)", exp_name, act, exp_o);
      end
    end
    if (lit_seq != lit_seen) begin
      nc++;
      if (((act ^ lit_exp) & lit_mask) !== '0) begin
        ne++;
        $display("FAIL %s: got %h expected %h under mask %h", lit_name, act, lit_exp, lit_mask);
      end
    end
    lit_seen <= lit_seq;
    n_checks <= n_checks + nc;
    n_errors <= n_errors + ne;
  end

  // ---------------- behavioural model ----------------
  function automatic bit legal(input logic [6:0] o, input logic [2:0] f3);
    if (o == OP_LW || o == OP_SW || o == OP_LUI) return 1'b1;
    if (o == OP_R || o == OP_I) return (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd6 || f3 == 3'd2);
    if (o == OP_BR) return (f3 == 3'd0 || f3 == 3'd1);
    return 1'b0;
  endfunction

  function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd7:    return 3'b010;
      3'd6:    return 3'b011;
      3'd2:    return 3'b101;
      default: return sub ? 3'b001 : 3'b000;
    endcase
  endfunction

  function automatic outs_t ph(input string p, input bit mr, input bit z);
    outs_t e;
    e = '0;
    case (p)
      "FETCH":     begin e.alu_src_b = 2'b10; e.result_src = 2'b10; e.ir_write = mr; e.pc_write = mr; end
      "DECODE":    begin
        e.alu_src_a = 2'b01; e.alu_src_b = 2'b01;
        e.imm_src = (op == OP_SW) ? 2'b01 : (op == OP_BR) ? 2'b10 : (op == OP_LUI) ? 2'b11 : 2'b00;
      end
      "MEM_ADR":   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.imm_src = (op == OP_SW) ? 2'b01 : 2'b00; end
      "MEM_READ":  e.adr_src = 1'b1;
      "MEM_WB":    begin e.result_src = 2'b01; e.reg_write = 1'b1; end
      "MEM_WRITE": begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
      "EXEC_R":    begin e.alu_src_a = 2'b10; e.alu_control = alu_ref(funct3, funct7_5); end
      "EXEC_I":    begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_control = alu_ref(funct3, 1'b0); end
      "LUI":       begin e.alu_src_a = 2'b11; e.alu_src_b = 2'b01; e.imm_src = 2'b11; end
      "ALU_WB":    e.reg_write = 1'b1;
      "BRANCH":    begin e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = (funct3 == 3'd0) ? z : ~z; end
      "ILLEGAL":   e.trap = 1'b1;
      default:     e = '0;
    endcase
    e.retired = mdl_retired;
    return e;
  endfunction

  function automatic bit retires(input string p, input bit mr);
    return (p == "MEM_WB") || (p == "ALU_WB") || (p == "BRANCH") || (p == "MEM_WRITE" && mr);
  endfunction

  // ---------------- stimulus ----------------
  // entered just after a rising edge; returns just after the next one
  task automatic step(input string p, input bit mr, input bit z);
    mem_ready = mr;
    zero = z;
    exp_o = ph(p, mr, z);
    exp_name = p;
    exp_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    if (retires(p, mr)) mdl_retired++;
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic post_lit(input string name, input outs_t e, input outs_t m);
    lit_exp = e; lit_mask = m; lit_name = name;
    lit_seq++;
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input bit z, input int wf, input int wm);
    for (int i = 0; i <= wf; i++) begin
      op = 7'($urandom); funct3 = 3'($urandom);  // IR not yet loaded
      step("FETCH", i == wf, rb());
    end
    op = o; funct3 = f3; funct7_5 = f7;
    step("DECODE", rb(), rb());
    if (!legal(o, f3)) begin
      for (int i = 0; i < 3; i++) step("ILLEGAL", rb(), rb());
    end else if (o == OP_LW) begin
      step("MEM_ADR", rb(), rb());
      for (int i = 0; i <= wm; i++) step("MEM_READ", i == wm, rb());
      step("MEM_WB", rb(), rb());
    end else if (o == OP_SW) begin
      step("MEM_ADR", rb(), rb());
      for (int i = 0; i <= wm; i++) step("MEM_WRITE", i == wm, rb());
    end else if (o == OP_R) begin
      step("EXEC_R", rb(), rb());
      step("ALU_WB", rb(), rb());
    end else if (o == OP_I) begin
      step("EXEC_I", rb(), rb());
      step("ALU_WB", rb(), rb());
    end else if (o == OP_LUI) begin
      step("LUI", rb(), rb());
      step("ALU_WB", rb(), rb());
    end else begin
      step("BRANCH", rb(), z);
    end
  endtask

  task automatic do_reset();
    exp_valid = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    mdl_retired = 0;
    @(posedge clk);
    #1;
  endtask

  outs_t e, m;
  logic [2:0] alu_f3 [4] = '{3'd0, 3'd7, 3'd6, 3'd2};

  initial begin
    // reset state with mem_ready low: FETCH decoding, nothing enabled
    #3;
    e = '0; m = '0;
    m.pc_write = 1'b1; m.ir_write = 1'b1; m.mem_write = 1'b1; m.trap = 1'b1; m.retired = '1;
    post_lit("reset_state", e, m);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // add, no waits: 4 cycles, one retire
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 0, 0);
    e = '0; m = '0; e.retired = 32'd1; m.retired = '1;
    post_lit("retired_after_add", e, m);
    run_instr(OP_LW, 3'd2, 1'b0, 1'b0, 0, 2);
    run_instr(OP_SW, 3'd2, 1'b0, 1'b0, 1, 2);
    run_instr(OP_BR, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BR, 3'd1, 1'b0, 1'b1, 0, 0);
    run_instr(OP_LUI, 3'd5, 1'b0, 1'b0, 0, 0);
    run_instr(OP_R, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(OP_I, 3'd2, 1'b1, 1'b0, 0, 0);
    e = '0; m = '0; e.retired = 32'd8; m.retired = '1;
    post_lit("retired_after_directed", e, m);

    // randomized legal instruction mix
    for (int n = 0; n < 150; n++) begin
      int cls;
      logic [2:0] f3;
      cls = $urandom_range(0, 5);
      f3 = alu_f3[$urandom_range(0, 3)];
      case (cls)
        0: run_instr(OP_LW, 3'd2, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        1: run_instr(OP_SW, 3'd2, rb(), rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        2: run_instr(OP_R, f3, rb(), rb(), $urandom_range(0, 2), 0);
        3: run_instr(OP_I, f3, rb(), rb(), $urandom_range(0, 2), 0);
        4: run_instr(OP_BR, 3'($urandom_range(0, 1)), rb(), rb(), $urandom_range(0, 2), 0);
        default: run_instr(OP_LUI, 3'($urandom), rb(), rb(), $urandom_range(0, 2), 0);
      endcase
    end

    // counter wrap: preset just below 2^32, two retires land on 0
    force dut.retired_q = 32'hFFFF_FFFE;
    #1 release dut.retired_q;
    mdl_retired = 32'hFFFF_FFFE;
    run_instr(OP_R, 3'd7, 1'b0, 1'b0, 0, 0);
    run_instr(OP_I, 3'd0, 1'b0, 1'b0, 0, 0);
    e = '0; m = '0; m.retired = '1;
    post_lit("retired_wrap", e, m);

    // reset in the middle of a stalled store
    run_instr(OP_R, 3'd6, 1'b0, 1'b0, 0, 0);
    step("FETCH", 1'b1, 1'b0);
    op = OP_SW; funct3 = 3'd2;
    step("DECODE", 1'b0, 1'b0);
    step("MEM_ADR", 1'b0, 1'b0);
    step("MEM_WRITE", 1'b0, 1'b0);
    mem_ready = 1'b0;
    exp_valid = 1'b0;
    #1 rst = 1'b0;
    e = '0; m = '0;
    m.mem_write = 1'b1; m.pc_write = 1'b1; m.ir_write = 1'b1; m.trap = 1'b1; m.retired = '1;
    post_lit("reset_mid_store", e, m);
    @(negedge clk);
    #2 rst = 1'b1;
    mdl_retired = 0;
    @(posedge clk); #1;

    // illegal funct3 on an R-type
    run_instr(OP_R, 3'd1, 1'b0, 1'b0, 0, 0);
    do_reset();

    // illegal opcode after two retires: trap holds, count frozen
    run_instr(OP_R, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_LUI, 3'd0, 1'b0, 1'b0, 0, 0);
    step("FETCH", 1'b1, 1'b0);
    op = 7'b1111111;
    step("DECODE", 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step("ILLEGAL", rb(), rb());
    e = '0; m = '0; e.trap = 1'b1; e.retired = 32'd2; m.trap = 1'b1; m.retired = '1;
    m.pc_write = 1'b1; m.mem_write = 1'b1; m.reg_write = 1'b1;
    post_lit("illegal_hold", e, m);
    step("ILLEGAL", 1'b1, 1'b1);
    exp_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
